// File: rtl/ctrl_reg_pkg.sv
// Shared address map, command bit indices and address decode helper for the
// host<->FPGA control/status register file.
package ctrl_reg_pkg;

  localparam int unsigned ADDR_EOF    = 0;
  localparam int unsigned ADDR_THR_EN = 1;
  localparam int unsigned ADDR_CMD    = 2;

  localparam int unsigned CMD_STAT_CLR  = 0;
  localparam int unsigned CMD_STAT_SNAP = 1;

  // Status counters occupy the top n_stat addresses of the map.
  function automatic logic is_stat_addr(input int unsigned addr,
                                        input int unsigned depth,
                                        input int unsigned n_stat);
    return addr >= (depth - n_stat);
  endfunction

endpackage

// File: rtl/ctrl_reg_file_if.sv
// Host register-bus port of ctrl_reg_file: one shared address for reads and
// writes, registered read data with a valid pulse, and a dropped-write flag.
interface ctrl_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);

  logic [DATA_W-1:0] din;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              wr_err;

  modport master (
    output din, we, re, addr,
    input  dout, dout_vld, wr_err
  );

  modport slave (
    input  din, we, re, addr,
    output dout, dout_vld, wr_err
  );

endinterface

// File: rtl/ctrl_reg_file_stat_counter.sv
// Saturating event counter (module stat_counter); a clear takes priority over
// a same-cycle increment.
module stat_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/ctrl_reg_file.sv
// Host command/status register file: writable control regs, a self-clearing
// command strobe at ADDR_CMD and read-only saturating event counters on top.
// Optional: define CTRL_REG_SNAPSHOT_EN for coherent shadowed status reads.
module ctrl_reg_file
  import ctrl_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_STAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_reg_file_if.slave    bus,
  output logic              eof,
  output logic              thr_en,
  output logic [DATA_W-1:0] cmd_pulse,
  input  logic [N_STAT-1:0] stat_inc
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int STAT_BASE = DEPTH - N_STAT;
  localparam int CTRL_N    = STAT_BASE;
  localparam int CIDX_W    = $clog2(CTRL_N);
  localparam int SIDX_W    = (N_STAT > 1) ? $clog2(N_STAT) : 1;

  logic              is_stat;
  logic              is_cmd;
  logic [CIDX_W-1:0] cidx;
  logic [SIDX_W-1:0] sidx;

  logic [DATA_W-1:0] ctrl_q [CTRL_N];
  logic [DATA_W-1:0] ctrl_d [CTRL_N];
  logic [DATA_W-1:0] cmd_pulse_q, cmd_pulse_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              wr_err_q, wr_err_d;

  logic [DATA_W-1:0] cnt [N_STAT];
  logic              stat_clr;
  logic [DATA_W-1:0] stat_rd;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    is_stat = is_stat_addr(32'(bus.addr), DEPTH, N_STAT);
    is_cmd  = (bus.addr == ADDR_W'(ADDR_CMD));
    cidx    = bus.addr[CIDX_W-1:0];
    sidx    = SIDX_W'(bus.addr - ADDR_W'(STAT_BASE));
  end

  // The command strobe is registered, so the clear lands one cycle after the write.
  assign stat_clr = cmd_pulse_q[CMD_STAT_CLR];

  for (genvar i = 0; i < N_STAT; i++) begin : g_stat
    stat_counter #(.DATA_W(DATA_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stat_inc[i]),
      .clr   (stat_clr),
      .q     (cnt[i])
    );
  end

`ifdef CTRL_REG_SNAPSHOT_EN
  logic              stat_snap;
  logic [DATA_W-1:0] shadow_q [N_STAT];
  logic [DATA_W-1:0] shadow_d [N_STAT];

  assign stat_snap = cmd_pulse_q[CMD_STAT_SNAP];

  // Counters still hold their old value during the clear cycle, so zero explicitly.
  always_comb begin
    shadow_d = shadow_q;
    if (stat_snap) begin
      for (int i = 0; i < N_STAT; i++) begin
        shadow_d[i] = stat_clr ? '0 : cnt[i];
      end
    end
    stat_rd = shadow_q[sidx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STAT; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign stat_rd = cnt[sidx];
`endif

  always_comb begin
    ctrl_d = ctrl_q;
    if (bus.we && !is_stat && !is_cmd) begin
      ctrl_d[cidx] = bus.din;
    end
    cmd_pulse_d = (bus.we && is_cmd) ? bus.din : '0;
    wr_err_d    = bus.we && is_stat;
    dout_vld_d  = bus.re;

    if (is_stat) begin
      rd_val = stat_rd;
    end else if (is_cmd) begin
      rd_val = '0;
    end else begin
      rd_val = ctrl_q[cidx];
    end
    dout_d = bus.re ? rd_val : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CTRL_N; i++) begin
        ctrl_q[i] <= '0;
      end
      cmd_pulse_q <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      cmd_pulse_q <= cmd_pulse_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.wr_err   = wr_err_q;
  assign eof          = ctrl_q[ADDR_EOF][0];
  assign thr_en       = ctrl_q[ADDR_THR_EN][0];
  assign cmd_pulse    = cmd_pulse_q;

endmodule

// File: tb/tb_ctrl_reg_file.sv
// Self-checking bench for ctrl_reg_file: read data is scoreboarded through a
// queue, the control/strobe outputs are checked inline per scenario.
module tb_ctrl_reg_file;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int N_STAT    = 8;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int STAT_BASE = DEPTH - N_STAT;

`ifdef CTRL_REG_SNAPSHOT_EN
  localparam logic [DATA_W-1:0] SNAP_MID = 16'd5;
`else
  localparam logic [DATA_W-1:0] SNAP_MID = 16'd8;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              eof;
  logic              thr_en;
  logic [DATA_W-1:0] cmd_pulse;
  logic [N_STAT-1:0] stat_inc;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  ctrl_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ctrl_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_STAT(N_STAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .eof       (eof),
    .thr_en    (thr_en),
    .cmd_pulse (cmd_pulse),
    .stat_inc  (stat_inc)
  );

  always #5 clk = ~clk;

  // Every dout_vld pulse must consume exactly one queued expectation, in order.
  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL read_unexpected: dout_vld=1 dout=%h, no read pending", bus.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.dout !== mon_exp) begin
          errors++;
          $display("[TB] FAIL read_data: dout=%h expected %h", bus.dout, mon_exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  task automatic bus_idle();
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.re   = 1'b0;
    bus.addr = a;
    bus.din  = d;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    @(negedge clk);
    bus.we   = 1'b0;
    bus.re   = 1'b1;
    bus.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic bus_wr_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] e);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.re   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
    stat_inc = '0;
    #12;
    checks++;
    if ({eof, thr_en, cmd_pulse, bus.dout, bus.dout_vld, bus.wr_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: eof=%b thr_en=%b cmd=%h dout=%h vld=%b err=%b, expected all 0",
               eof, thr_en, cmd_pulse, bus.dout, bus.dout_vld, bus.wr_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bus_read(ADDR_W'(a), '0);
    end
    bus_idle();
    checks++;
    if (bus.dout_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL vld_latency: dout_vld=%b one cycle after re, expected 1", bus.dout_vld);
    end
    bus_idle();
    checks++;
    if (bus.dout_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL vld_pulse: dout_vld=%b two cycles after last re, expected 0", bus.dout_vld);
    end
  endtask

  task automatic test_write_read();
    bus_write(ADDR_W'(1), 16'h0001);
    bus_idle();
    checks++;
    if (thr_en !== 1'b1 || eof !== 1'b0) begin
      errors++;
      $display("[TB] FAIL thr_en_write: thr_en=%b eof=%b, expected 1/0", thr_en, eof);
    end
    bus_write(ADDR_W'(5), 16'hABCD);
    bus_read(ADDR_W'(5), 16'hABCD);
    bus_wr_rd(ADDR_W'(5), 16'h1234, 16'hABCD);
    bus_read(ADDR_W'(5), 16'h1234);
    repeat (3) bus_idle();
    checks++;
    if (bus.dout !== 16'h1234 || bus.dout_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dout_hold: dout=%h vld=%b, expected 1234/0", bus.dout, bus.dout_vld);
    end
    bus_write(ADDR_W'(0), 16'h0001);
    bus_idle();
    checks++;
    if (eof !== 1'b1 || bus.wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL eof_write: eof=%b wr_err=%b, expected 1/0", eof, bus.wr_err);
    end
  endtask

  task automatic test_ro_and_cmd();
    bus_write(ADDR_W'(DEPTH - 1), 16'h00FF);
    bus_idle();
    checks++;
    if (bus.wr_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_err_pulse: wr_err=%b, expected 1", bus.wr_err);
    end
    bus_idle();
    checks++;
    if (bus.wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_err_width: wr_err=%b, expected 0", bus.wr_err);
    end
    bus_read(ADDR_W'(DEPTH - 1), '0);
    bus_write(ADDR_W'(2), 16'h0081);
    bus_idle();
    checks++;
    if (cmd_pulse !== 16'h0081) begin
      errors++;
      $display("[TB] FAIL cmd_pulse: cmd_pulse=%h, expected 0081", cmd_pulse);
    end
    bus_idle();
    checks++;
    if (cmd_pulse !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL cmd_pulse_clear: cmd_pulse=%h, expected 0000", cmd_pulse);
    end
    bus_read(ADDR_W'(2), '0);
    bus_read(ADDR_W'(0), 16'h0001);
    bus_idle();
  endtask

  task automatic test_counters();
    bus_idle();
    stat_inc = 8'h01;
    repeat (10) bus_idle();
    stat_inc = '0;
    bus_read(ADDR_W'(STAT_BASE), 16'd10);
    stat_inc = 8'h01;
    bus_read(ADDR_W'(STAT_BASE), 16'd11);
    stat_inc = '0;
    bus_write(ADDR_W'(2), 16'h0001);
    stat_inc = 8'h01;
    bus_idle();
    bus_read(ADDR_W'(STAT_BASE), '0);
    stat_inc = '0;
    bus_idle();
    stat_inc = 8'h02;
    repeat (65540) @(negedge clk);
    stat_inc = '0;
    bus_read(ADDR_W'(STAT_BASE + 1), 16'hFFFF);
    bus_read(ADDR_W'(STAT_BASE + 2), '0);
    bus_idle();
  endtask

  task automatic test_snapshot();
    bus_idle();
    stat_inc = 8'h01;
    repeat (5) bus_idle();
    stat_inc = '0;
    bus_write(ADDR_W'(2), 16'h0002);
    bus_idle();
    bus_idle();
    stat_inc = 8'h01;
    repeat (3) bus_idle();
    stat_inc = '0;
    bus_read(ADDR_W'(STAT_BASE), SNAP_MID);
    bus_write(ADDR_W'(2), 16'h0002);
    bus_idle();
    bus_idle();
    bus_read(ADDR_W'(STAT_BASE), 16'd8);
    bus_write(ADDR_W'(2), 16'h0003);
    bus_idle();
    bus_idle();
    bus_read(ADDR_W'(STAT_BASE), '0);
    bus_idle();
  endtask

  task automatic test_reset_mid();
    bus_write(ADDR_W'(0), 16'h0001);
    bus_write(ADDR_W'(1), 16'h0001);
    bus_idle();
    stat_inc = 8'h04;
    repeat (3) bus_idle();
    @(negedge clk);
    bus.re   = 1'b1;
    bus.addr = ADDR_W'(1);
    @(posedge clk);
    #2;
    checks++;
    if (bus.dout_vld !== 1'b1 || bus.dout !== 16'h0001 || eof !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_state: vld=%b dout=%h eof=%b, expected 1/0001/1",
               bus.dout_vld, bus.dout, eof);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({eof, thr_en, cmd_pulse, bus.dout, bus.dout_vld, bus.wr_err} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: eof=%b thr_en=%b cmd=%h dout=%h vld=%b err=%b, expected all 0",
               eof, thr_en, cmd_pulse, bus.dout, bus.dout_vld, bus.wr_err);
    end
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    stat_inc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bus_read(ADDR_W'(a), '0);
    end
    bus_idle();
    bus_idle();
    checks++;
    if (eof !== 1'b0 || thr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_ctrl: eof=%b thr_en=%b, expected 0/0", eof, thr_en);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ro_and_cmd();
    test_counters();
    test_snapshot();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_reads: %0d reads never returned dout_vld, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
